avalon_stream_guard: RTL

Parametrised successor to the single-beat Avalon-ST enforcer. It accepts an untrusted Avalon-ST stream and emits a protocol-clean stream through a registered output stage. It drops beats outside a message and truncates over-long messages with a forced EOP, then discards their tail. It reports violations as pulses and, optionally, as saturating counters. It sits between any external or untrusted stream source and internal stream consumers.

---
 rtl/avalon_guard_pack.sv | 30 +++
 rtl/avalon_st_if.sv | 18 +
 rtl/avalon_st_reg_slice.sv | 49 ++++
 rtl/avalon_stream_guard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_guard_pack.sv
// Shared definitions for the Avalon-ST stream guard.
//   guard_sm_t : message-tracking states of the guard FSM
//   keep_mask  : per-byte keep mask derived from an EOP empty count
package avalon_guard_pack;

    typedef enum logic [1:0] {
        BETWEEN_MSG = 2'd0,
        IN_MSG      = 2'd1,
        DISCARD     = 2'd2
    } guard_sm_t;

    // Widest bus the mask helper supports; callers cast the result down
    // to their own byte count.
    localparam int unsigned MAX_BYTES = 128;

    // Bit i set means byte i survives. Bytes below the empty count are
    // dropped; an empty count at or beyond nbytes drops the whole beat.
    function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned empty,
                                                       input int unsigned nbytes);
        logic [MAX_BYTES-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if ((i < nbytes) && (i >= empty)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bundle: data/empty/sop/eop/valid forward, rdy backward.
//   master : drives data, empty, sop, eop, valid; observes rdy
//   slave  : observes data, empty, sop, eop, valid; drives rdy
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic [EMPTY_W-1:0]               empty;
    logic                             sop;
    logic                             eop;
    logic                             valid;
    logic                             rdy;

    modport master (output data, empty, sop, eop, valid, input rdy);
    modport slave  (input data, empty, sop, eop, valid, output rdy);
endinterface

// File: rtl/avalon_st_reg_slice.sv
// Single-entry registered output stage for an Avalon-ST beat.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_*     : beat offered by the guard logic
//   in_rdy            : stage can take a beat this cycle
//   out_valid/out_*   : registered beat towards the sink
//   out_rdy           : sink ready
// Upstream readiness depends only on this stage, so beats the guard
// decides to drop are consumed at the same rate as forwarded ones.
module avalon_st_reg_slice #(
    parameter int DATA_W  = 128,
    parameter int EMPTY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_rdy,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_rdy
);

    assign in_rdy = ~out_valid | out_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_empty <= '0;
            out_data  <= '0;
        end else if (in_rdy) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_sop   <= in_sop;
                out_eop   <= in_eop;
                out_empty <= in_empty;
                out_data  <= in_data;
            end
        end
    end

endmodule

// File: rtl/avalon_stream_guard.sv
// Avalon-ST protocol guard between an untrusted source and internal sinks.
// Drops beats outside a message, clears stray SOPs inside one, truncates
// messages at MAX_MSG_BEATS with a forced EOP and discards their tail.
//   clk, rst        : clock, asynchronous active-low reset
//   untrusted_msg   : input stream (slave)
//   enforced_msg    : cleaned stream, registered, 1-cycle latency (master)
//   missing_sop     : pulse, non-SOP beat accepted between messages
//   unexpected_sop  : pulse, SOP beat accepted inside a message or discard
//   truncated       : pulse, message forced closed at MAX_MSG_BEATS
//   *_cnt           : saturating violation counters, only when
//                     AVALON_STREAM_GUARD_ERR_CNT_EN is defined
//
// state       | meaning
// BETWEEN_MSG | waiting for an SOP; non-SOP beats are dropped
// IN_MSG      | forwarding a message, counting its beats
// DISCARD     | dropping the tail of a truncated message up to its EOP
module avalon_stream_guard
    import avalon_guard_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_BEATS       = 64,
    parameter int CNT_WIDTH           = 16
) (
    input  logic               clk,
    input  logic               rst,
    avalon_st_if.slave         untrusted_msg,
    avalon_st_if.master        enforced_msg,
    output logic               missing_sop,
    output logic               unexpected_sop,
    output logic               truncated
`ifdef AVALON_STREAM_GUARD_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
    output logic [CNT_WIDTH-1:0] truncated_cnt
`endif
);

    localparam int DATA_W     = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_W    = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam int BEAT_CNT_W = $clog2(MAX_MSG_BEATS + 1);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_MSG_BEATS);

    guard_sm_t               state;
    guard_sm_t               state_nxt;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [BEAT_CNT_W-1:0]   beat_cnt_nxt;
    logic [BEAT_CNT_W-1:0]   beat_cnt_inc;

    logic                    rdy;
    logic                    accept;
    logic                    fwd;
    logic                    fwd_sop;
    logic                    fwd_eop;
    logic [EMPTY_W-1:0]      fwd_empty;
    logic [DATA_W-1:0]       fwd_data;
    logic [DATA_WIDTH_IN_BYTES-1:0] keep;

    logic                    missing_sop_nxt;
    logic                    unexpected_sop_nxt;
    logic                    truncated_nxt;

    assign accept            = untrusted_msg.valid & rdy;
    assign untrusted_msg.rdy = rdy;
    // Only reached below LAST_BEAT, so the increment cannot wrap.
    assign beat_cnt_inc      = beat_cnt + BEAT_CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BETWEEN_MSG;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // beat_cnt is 0 outside IN_MSG, so in BETWEEN_MSG beat_cnt_inc is the
    // first beat's count and MAX_MSG_BEATS=1 truncates on the SOP beat.
    always_comb begin
        state_nxt          = state;
        beat_cnt_nxt       = beat_cnt;
        fwd                = 1'b0;
        fwd_sop            = 1'b0;
        fwd_eop            = untrusted_msg.eop;
        missing_sop_nxt    = 1'b0;
        unexpected_sop_nxt = 1'b0;
        truncated_nxt      = 1'b0;
        if (accept) begin
            unique case (state)
                BETWEEN_MSG: begin
                    if (untrusted_msg.sop) begin
                        fwd     = 1'b1;
                        fwd_sop = 1'b1;
                        if (!untrusted_msg.eop) begin
                            if (beat_cnt_inc == LAST_BEAT) begin
                                fwd_eop       = 1'b1;
                                truncated_nxt = 1'b1;
                                state_nxt     = DISCARD;
                            end else begin
                                state_nxt    = IN_MSG;
                                beat_cnt_nxt = beat_cnt_inc;
                            end
                        end
                    end else begin
                        missing_sop_nxt = 1'b1;
                    end
                end
                IN_MSG: begin
                    fwd                = 1'b1;
                    unexpected_sop_nxt = untrusted_msg.sop;
                    if (untrusted_msg.eop) begin
                        state_nxt    = BETWEEN_MSG;
                        beat_cnt_nxt = '0;
                    end else if (beat_cnt_inc == LAST_BEAT) begin
                        fwd_eop       = 1'b1;
                        truncated_nxt = 1'b1;
                        state_nxt     = DISCARD;
                        beat_cnt_nxt  = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt_inc;
                    end
                end
                DISCARD: begin
                    unexpected_sop_nxt = untrusted_msg.sop;
                    if (untrusted_msg.eop) begin
                        state_nxt = BETWEEN_MSG;
                    end
                end
                default: begin
                    state_nxt    = BETWEEN_MSG;
                    beat_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A forced EOP comes from a beat whose own eop was 0, so keying empty
    // on the incoming eop also yields empty=0 for truncated beats.
    assign fwd_empty = untrusted_msg.eop ? untrusted_msg.empty : '0;

    always_comb begin
        keep     = DATA_WIDTH_IN_BYTES'(keep_mask(32'(fwd_empty), DATA_WIDTH_IN_BYTES));
        fwd_data = '0;
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
            fwd_data[8*i +: 8] = keep[i] ? untrusted_msg.data[8*i +: 8] : 8'h00;
        end
    end

    avalon_st_reg_slice #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fwd),
        .in_sop    (fwd_sop),
        .in_eop    (fwd_eop),
        .in_empty  (fwd_empty),
        .in_data   (fwd_data),
        .in_rdy    (rdy),
        .out_valid (enforced_msg.valid),
        .out_sop   (enforced_msg.sop),
        .out_eop   (enforced_msg.eop),
        .out_empty (enforced_msg.empty),
        .out_data  (enforced_msg.data),
        .out_rdy   (enforced_msg.rdy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            missing_sop    <= 1'b0;
            unexpected_sop <= 1'b0;
            truncated      <= 1'b0;
        end else begin
            missing_sop    <= missing_sop_nxt;
            unexpected_sop <= unexpected_sop_nxt;
            truncated      <= truncated_nxt;
        end
    end

`ifdef AVALON_STREAM_GUARD_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            missing_sop_cnt    <= '0;
            unexpected_sop_cnt <= '0;
            truncated_cnt      <= '0;
        end else begin
            if (missing_sop_nxt && (missing_sop_cnt != '1)) begin
                missing_sop_cnt <= missing_sop_cnt + CNT_WIDTH'(1);
            end
            if (unexpected_sop_nxt && (unexpected_sop_cnt != '1)) begin
                unexpected_sop_cnt <= unexpected_sop_cnt + CNT_WIDTH'(1);
            end
            if (truncated_nxt && (truncated_cnt != '1)) begin
                truncated_cnt <= truncated_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
